// File: rtl/axis_packet_generator.sv
// Synthetic AXI Stream packet source. A command gives the packet length, the
// packet count and the idle gap between packets. Every emitted packet is AXIS-conformant.
module axis_packet_generator #(
    parameter int axis_data_width          = 256,
    parameter int axis_tkeep_width         = axis_data_width / 8,
    parameter int axis_tkeep_encoded_width = $clog2(axis_tkeep_width),
    parameter int length_width             = 16,
    parameter int count_width              = 16,
    parameter int gap_width                = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic [length_width-1:0]             cmd_length,
    input  logic [count_width-1:0]              cmd_count,
    input  logic [gap_width-1:0]                cmd_gap,
    output logic                                cmd_error,
    output logic [axis_data_width-1:0]          m_axis_tdata,
    output logic [axis_tkeep_width-1:0]         m_axis_tkeep,
    output logic [axis_tkeep_encoded_width-1:0] m_axis_tkeep_encoded,
    output logic                                m_axis_tlast,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic                                busy,
    output logic [count_width-1:0]              packets_sent
);

    // The byte index carries one extra bit so that idx + W cannot wrap
    // for lengths near the top of the range.
    localparam int                IDX_W      = length_width + 1;
    localparam logic [IDX_W-1:0]  BEAT_BYTES = IDX_W'(axis_tkeep_width);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t                  state_q, state_d;
    logic [length_width-1:0] len_q, len_d;
    logic [count_width-1:0]  count_q, count_d;
    logic [gap_width-1:0]    gap_q, gap_d;
    logic [gap_width-1:0]    gap_cnt_q, gap_cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [count_width-1:0]  packets_sent_q, packets_sent_d;
    logic                    cmd_error_q, cmd_error_d;

    logic [IDX_W-1:0]        remaining;
    logic [IDX_W-1:0]        nbytes;
    logic                    last_beat;
    logic                    sending;
    logic                    handshake;
    logic [count_width-1:0]  sent_inc;

    assign sending   = (state_q == SEND);
    assign handshake = sending & m_axis_tready;
    assign remaining = {1'b0, len_q} - idx_q;
    assign last_beat = (remaining <= BEAT_BYTES);
    assign nbytes    = last_beat ? remaining : BEAT_BYTES;
    assign sent_inc  = packets_sent_q + count_width'(1);

    // Beat contents depend only on registered state, so they stay stable across stalls.
    always_comb begin
        m_axis_tkeep = '0;
        m_axis_tdata = '0;
        for (int i = 0; i < axis_tkeep_width; i++) begin
            if (sending && (IDX_W'(i) < nbytes)) begin
                m_axis_tkeep[i]      = 1'b1;
                m_axis_tdata[i*8 +: 8] = idx_q[7:0] + 8'(i);
            end
        end
    end

    assign m_axis_tkeep_encoded = sending ? axis_tkeep_encoded_width'(nbytes - IDX_W'(1)) : '0;
    assign m_axis_tlast         = sending & last_beat;
    assign m_axis_tvalid        = sending;
    assign cmd_ready            = (state_q == IDLE);
    assign busy                 = (state_q != IDLE);
    assign cmd_error            = cmd_error_q;
    assign packets_sent         = packets_sent_q;

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        count_d        = count_q;
        gap_d          = gap_q;
        gap_cnt_d      = gap_cnt_q;
        idx_d          = idx_q;
        packets_sent_d = packets_sent_q;
        cmd_error_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_length == '0 || cmd_count == '0) begin
                        cmd_error_d = 1'b1;
                    end else begin
                        len_d          = cmd_length;
                        count_d        = cmd_count;
                        gap_d          = cmd_gap;
                        idx_d          = '0;
                        packets_sent_d = '0;
                        state_d        = SEND;
                    end
                end
            end
            SEND: begin
                if (handshake) begin
                    if (last_beat) begin
                        packets_sent_d = sent_inc;
                        idx_d          = '0;
                        if (sent_inc == count_q) begin
                            state_d = IDLE;
                        end else if (gap_q != '0) begin
                            state_d   = GAP;
                            gap_cnt_d = gap_q;
                        end
                    end else begin
                        idx_d = idx_q + BEAT_BYTES;
                    end
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q - gap_width'(1);
                if (gap_cnt_q == gap_width'(1)) state_d = SEND;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            len_q          <= '0;
            count_q        <= '0;
            gap_q          <= '0;
            gap_cnt_q      <= '0;
            idx_q          <= '0;
            packets_sent_q <= '0;
            cmd_error_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            count_q        <= count_d;
            gap_q          <= gap_d;
            gap_cnt_q      <= gap_cnt_d;
            idx_q          <= idx_d;
            packets_sent_q <= packets_sent_d;
            cmd_error_q    <= cmd_error_d;
        end
    end

endmodule

// File: tb/tb_axis_packet_generator.sv
// Bench for axis_packet_generator: directed and randomized commands checked against
// a packet model built from byte counts. Random sink back-pressure is applied.
module tb_axis_packet_generator;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [15:0]  cmd_length;
    logic [15:0]  cmd_count;
    logic [7:0]   cmd_gap;
    logic         cmd_error;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tkeep;
    logic [4:0]   m_axis_tkeep_encoded;
    logic         m_axis_tlast;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         busy;
    logic [15:0]  packets_sent;

    int n_checks = 0;
    int n_fail   = 0;

    axis_packet_generator dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_length(cmd_length),
        .cmd_count(cmd_count), .cmd_gap(cmd_gap), .cmd_error(cmd_error),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tkeep_encoded(m_axis_tkeep_encoded), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .busy(busy), .packets_sent(packets_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: a packet of len bytes is a list of beats. Beat b holds bytes b*W .. min(len,(b+1)*W)-1.
    function automatic int beat_bytes(input int len, input int b);
        int n = len - b * W;
        return (n > W) ? W : n;
    endfunction

    function automatic logic [31:0] exp_keep(input int len, input int b);
        logic [31:0] k = '0;
        for (int i = 0; i < beat_bytes(len, b); i++) k[i] = 1'b1;
        return k;
    endfunction

    function automatic logic [255:0] exp_data(input int len, input int b);
        logic [255:0] d = '0;
        for (int i = 0; i < beat_bytes(len, b); i++) d[i*8 +: 8] = 8'((b * W + i) % 256);
        return d;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_tvalid"}, m_axis_tvalid, 0);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_tkeep"}, m_axis_tkeep, 0);
        chk({tag, "_tdata"}, m_axis_tdata, 0);
        chk({tag, "_tlast"}, m_axis_tlast, 0);
        chk({tag, "_enc"}, m_axis_tkeep_encoded, 0);
    endtask

    // Issues one command at the current negedge and follows it to the end.
    task automatic run_cmd(input int len, input int cnt, input int gp, input bit rnd);
        int nb = (len + W - 1) / W;
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_length = 16'(len); cmd_count = 16'(cnt); cmd_gap = 8'(gp);
        @(negedge clk);
        // Offer an illegal command throughout; it must be ignored outside IDLE.
        cmd_length = '0; cmd_count = '0;
        chk("tvalid_latency1", m_axis_tvalid, 1);
        chk("busy_send", busy, 1);
        chk("cmd_ready_busy", cmd_ready, 0);
        chk("packets_sent_clear", packets_sent, 0);
        for (int p = 0; p < cnt; p++) begin
            if (p > 0) begin
                int idle = 0;
                while (!m_axis_tvalid && idle < 300) begin
                    idle++;
                    @(negedge clk);
                end
                chk("gap_cycles", idle, gp);
            end
            for (int b = 0; b < nb; b++) begin
                int  cyc = 0;
                bit  hs;
                do begin
                    m_axis_tready = rnd ? 1'($urandom % 2) : 1'b1;
                    chk("tvalid_held", m_axis_tvalid, 1);
                    chk("tkeep", m_axis_tkeep, exp_keep(len, b));
                    chk("tkeep_enc", m_axis_tkeep_encoded, beat_bytes(len, b) - 1);
                    chk("tlast", m_axis_tlast, ((b + 1) * W >= len));
                    chk("tdata", m_axis_tdata, exp_data(len, b));
                    chk("no_cmd_error", cmd_error, 0);
                    hs = m_axis_tvalid && m_axis_tready;
                    @(negedge clk);
                    cyc++;
                end while (!hs && cyc < 1000);
                if (!hs) chk("stall_timeout", 0, 1);
            end
            chk("packets_sent", packets_sent, p + 1);
        end
        cmd_valid = 1'b0;
        check_idle("end_idle");
        chk("end_no_cmd_error", cmd_error, 0);
        m_axis_tready = 1'b0;
        @(negedge clk);
        check_idle("end_idle2");
        chk("end_packets_sent", packets_sent, cnt);
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_length = '0; cmd_count = '0; cmd_gap = '0;
        m_axis_tready = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        chk("reset_cmd_error", cmd_error, 0);
        chk("reset_packets_sent", packets_sent, 0);
        reset = 1'b0;
        @(negedge clk);

        // Short two-beat packet with a one-byte tail.
        run_cmd(33, 1, 0, 0);
        // Full beats, with a gap of two cycles between packets.
        run_cmd(64, 3, 2, 0);
        // Random back-pressure. The tail beat carries 4 bytes.
        run_cmd(100, 4, $urandom_range(0, 3), 1);
        // Packets of one beat each, sent back-to-back.
        run_cmd(32, 2, 0, 0);

        // Illegal commands: zero length, then zero count.
        cmd_valid = 1'b1; cmd_length = 16'd0; cmd_count = 16'd5;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("err_len0_pulse", cmd_error, 1);
        check_idle("err_len0");
        @(negedge clk);
        chk("err_len0_once", cmd_error, 0);
        cmd_valid = 1'b1; cmd_length = 16'd10; cmd_count = 16'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("err_cnt0_pulse", cmd_error, 1);
        check_idle("err_cnt0");
        @(negedge clk);
        chk("err_cnt0_once", cmd_error, 0);
        chk("err_cnt0_idle", m_axis_tvalid, 0);

        // Randomized commands.
        for (int t = 0; t < 6; t++)
            run_cmd($urandom_range(1, 200), $urandom_range(1, 3), $urandom_range(0, 3), 1);
        run_cmd(1, 1, 0, 1);

        // Reset while the third beat of a long packet is presented.
        cmd_valid = 1'b1; cmd_length = 16'd9500; cmd_count = 16'd1; cmd_gap = 8'd0;
        m_axis_tready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("long_beat2_tdata", m_axis_tdata, exp_data(9500, 2));
        chk("long_beat2_tvalid", m_axis_tvalid, 1);
        reset = 1'b1;
        @(negedge clk);
        check_idle("midreset");
        chk("midreset_packets_sent", packets_sent, 0);
        reset = 1'b0;
        run_cmd(40, 2, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
